// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-wide ripple slice
// walks the operands LSB-first, with valid/ready handshakes on both sides.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, dsum_w;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   c;
    logic             last;

    // Ripple slice; c[DIGIT-1] is the carry into the digit MSB, needed for ovf.
    always_comb begin
        c      = '0;
        dsum   = '0;
        c[0]   = carry;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
            c[i + 1] = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
        end
        dsum_w            = '0;
        dsum_w[DIGIT-1:0] = dsum;
        acc_nxt           = (acc >> DIGIT) | (dsum_w << (WIDTH - DIGIT));
    end

    assign last     = (cnt == LAST);
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= op_sub ? ~b : b;
                    carry <= cin ^ op_sub;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= acc_nxt;
                    carry <= c[DIGIT];
                    if (last) begin
                        sum       <= acc_nxt;
                        cout      <= c[DIGIT];
                        ovf       <= c[DIGIT] ^ c[DIGIT-1];
                        zero      <= (acc_nxt == '0);
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four configurations checked every cycle against an
// arithmetic/timing model, plus directed vectors with literal expectations.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_w(input int g);
        case (g)
            0: return 8;
            1: return 4;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            0: return 2;
            1: return 1;
            2: return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int n_of(input int g);
        return cfg_w(g) / cfg_d(g);
    endfunction

    logic        in_valid_s[4], in_ready_s[4], op_sub_s[4], cin_s[4];
    logic        out_valid_s[4], out_ready_s[4], cout_s[4], ovf_s[4], zero_s[4];
    logic [15:0] a_s[4], b_s[4], sum_s[4];

    for (genvar g = 0; g < 4; g++) begin : dut_g
        localparam int W = cfg_w(g);
        localparam int D = cfg_d(g);
        logic [W-1:0] a_l, b_l, sum_l;
        logic         rdy_l, ov_l, co_l, of_l, z_l;
        assign a_l = a_s[g][W-1:0];
        assign b_l = b_s[g][W-1:0];
        serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid_s[g]), .in_ready(rdy_l),
            .op_sub(op_sub_s[g]), .a(a_l), .b(b_l), .cin(cin_s[g]),
            .out_valid(ov_l), .out_ready(out_ready_s[g]),
            .sum(sum_l), .cout(co_l), .ovf(of_l), .zero(z_l)
        );
        assign in_ready_s[g]  = rdy_l;
        assign out_valid_s[g] = ov_l;
        assign sum_s[g]       = 16'(sum_l);
        assign cout_s[g]      = co_l;
        assign ovf_s[g]       = of_l;
        assign zero_s[g]      = z_l;
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input int g, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[cfg%0d] t=%0t: got %0h, expected %0h", nm, g, $time, act, exp);
        end
    endfunction

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    // Plain integer arithmetic: a+b+cin or a-b-cin, with signed range test for ovf.
    function automatic res_t model(input int w, input logic sub, input logic [15:0] av,
                                   input logic [15:0] bv, input logic c);
        longint m, half, ua, ub, full, sa, sb, tr;
        res_t r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        if (sub) full = ua + (~ub & m) + (c ? longint'(0) : longint'(1));
        else     full = ua + ub + longint'(c);
        r.s  = 16'(full & m);
        r.co = ((full >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        tr   = sub ? sa - sb - longint'(c) : sa + sb + longint'(c);
        r.ov = (tr >= half) || (tr < -half);
        r.z  = (r.s == 16'd0);
        return r;
    endfunction

    // Model: idle / busy for N edges / done until out_ready.
    bit   m_busy[4], m_done[4];
    int   m_left[4];
    res_t m_res[4], p_res[4];

    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 4; g++) begin
            if (!rst_n) begin
                m_busy[g] <= 1'b0;
                m_done[g] <= 1'b0;
                m_left[g] <= 0;
                m_res[g]  <= '0;
                p_res[g]  <= '0;
            end else if (!m_busy[g] && !m_done[g]) begin
                if (in_valid_s[g]) begin
                    p_res[g]  <= model(cfg_w(g), op_sub_s[g], a_s[g], b_s[g], cin_s[g]);
                    m_busy[g] <= 1'b1;
                    m_left[g] <= n_of(g);
                end
            end else if (m_busy[g]) begin
                if (m_left[g] == 1) begin
                    m_busy[g] <= 1'b0;
                    m_done[g] <= 1'b1;
                    m_res[g]  <= p_res[g];
                end
                m_left[g] <= m_left[g] - 1;
            end else if (out_ready_s[g]) begin
                m_done[g] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            chk("in_ready", g, 32'(in_ready_s[g]), 32'(!(m_busy[g] || m_done[g])));
            chk("out_valid", g, 32'(out_valid_s[g]), 32'(m_done[g]));
            chk("sum", g, 32'(sum_s[g]), 32'(m_res[g].s));
            chk("cout", g, 32'(cout_s[g]), 32'(m_res[g].co));
            chk("ovf", g, 32'(ovf_s[g]), 32'(m_res[g].ov));
            chk("zero", g, 32'(zero_s[g]), 32'(m_res[g].z));
        end
    end

    // Start an op, scramble inputs after acceptance, return edges until out_valid.
    task automatic issue(input int g, input logic sub, input logic [15:0] av,
                         input logic [15:0] bv, input logic c, input bit wait_edge,
                         output int lat);
        int guard;
        if (wait_edge) @(negedge clk);
        a_s[g] = av; b_s[g] = bv; op_sub_s[g] = sub; cin_s[g] = c; in_valid_s[g] = 1'b1;
        guard = 0;
        while (!in_ready_s[g] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready_s[g]) chk("accept_timeout", g, 32'(in_ready_s[g]), 32'd1);
        @(posedge clk);
        #1;
        in_valid_s[g] = 1'b0;
        a_s[g] = ~av; b_s[g] = ~bv; op_sub_s[g] = ~sub; cin_s[g] = ~c;
        lat = 0;
        while (!out_valid_s[g] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input int g);
        @(negedge clk);
        out_ready_s[g] = 1'b1;
        @(negedge clk);
        out_ready_s[g] = 1'b0;
    endtask

    task automatic op_check(input int g, input logic sub, input logic [15:0] av,
                            input logic [15:0] bv, input logic c, input bit wait_edge,
                            input logic [15:0] es, input logic eco, input logic eov,
                            input logic ez);
        int lat;
        issue(g, sub, av, bv, c, wait_edge, lat);
        chk("latency", g, 32'(lat), 32'(n_of(g)));
        chk("lit_sum", g, 32'(sum_s[g]), 32'(es));
        chk("lit_cout", g, 32'(cout_s[g]), 32'(eco));
        chk("lit_ovf", g, 32'(ovf_s[g]), 32'(eov));
        chk("lit_zero", g, 32'(zero_s[g]), 32'(ez));
        release_out(g);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int g = 0; g < 4; g++) begin
            in_valid_s[g] = 1'b0; op_sub_s[g] = 1'b0; cin_s[g] = 1'b0;
            out_ready_s[g] = 1'b0; a_s[g] = '0; b_s[g] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 0, 32'(in_ready_s[0]), 32'd1);
        chk("rst_out_valid", 0, 32'(out_valid_s[0]), 32'd0);
        chk("rst_sum", 0, 32'(sum_s[0]), 32'd0);

        // Accept on the first edge after reset release.
        rst_n = 1'b1;
        op_check(0, 1'b0, 16'h3C, 16'h05, 1'b0, 1'b0, 16'h41, 1'b0, 1'b0, 1'b0);

        op_check(0, 1'b1, 16'h05, 16'h07, 1'b0, 1'b1, 16'hFE, 1'b0, 1'b0, 1'b0);
        op_check(0, 1'b1, 16'h10, 16'h10, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1);
        op_check(0, 1'b1, 16'h10, 16'h0F, 1'b1, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1);
        op_check(0, 1'b0, 16'h7F, 16'h01, 1'b0, 1'b1, 16'h80, 1'b0, 1'b1, 1'b0);
        op_check(0, 1'b1, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0);
        op_check(0, 1'b0, 16'hFF, 16'h00, 1'b1, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1);

        // out_ready while idle does nothing.
        @(negedge clk); out_ready_s[0] = 1'b1;
        @(negedge clk); out_ready_s[0] = 1'b0;
        chk("idle_out_valid", 0, 32'(out_valid_s[0]), 32'd0);

        // Backpressure: result and handshake hold while new requests are ignored.
        issue(0, 1'b0, 16'h21, 16'h11, 1'b0, 1'b1, lat);
        chk("bp_latency", 0, 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid_s[0] = (i % 2 == 0);
            a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); op_sub_s[0] = 1'(i);
            chk("bp_out_valid", 0, 32'(out_valid_s[0]), 32'd1);
            chk("bp_in_ready", 0, 32'(in_ready_s[0]), 32'd0);
            chk("bp_sum", 0, 32'(sum_s[0]), 32'h32);
        end
        in_valid_s[0] = 1'b0;
        release_out(0);
        op_check(0, 1'b0, 16'h0A, 16'h0B, 1'b0, 1'b1, 16'h15, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        a_s[0] = 16'h55; b_s[0] = 16'h22; op_sub_s[0] = 1'b0; cin_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        @(posedge clk); #1; in_valid_s[0] = 1'b0;
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        chk("ar_in_ready", 0, 32'(in_ready_s[0]), 32'd1);
        chk("ar_out_valid", 0, 32'(out_valid_s[0]), 32'd0);
        chk("ar_sum", 0, 32'(sum_s[0]), 32'd0);
        chk("ar_cout", 0, 32'(cout_s[0]), 32'd0);
        chk("ar_ovf", 0, 32'(ovf_s[0]), 32'd0);
        chk("ar_zero", 0, 32'(zero_s[0]), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        op_check(0, 1'b0, 16'h12, 16'h34, 1'b0, 1'b1, 16'h46, 1'b0, 1'b0, 1'b0);

        // Pins for the other configurations.
        op_check(1, 1'b0, 16'h7, 16'h1, 1'b0, 1'b1, 16'h8, 1'b0, 1'b1, 1'b0);
        op_check(2, 1'b0, 16'hFF, 16'h01, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1);
        op_check(3, 1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0);

        for (int g = 1; g < 4; g++) begin
            for (int k = 0; k < 1000; k++) begin
                issue(g, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, lat);
                chk("rnd_latency", g, 32'(lat), 32'(n_of(g)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                release_out(g);
            end
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised digit-serial two's-complement adder/subtractor. It processes DIGIT bits per clock through one DIGIT-wide ripple-carry slice, so the arithmetic logic does not grow with WIDTH. It sits between operand sources and result consumers, with valid/ready handshakes on both sides. It reports carry, signed overflow and zero flags.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT, at least 2.
DIGIT, 2, bits processed per clock; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept an operation.
op_sub  input  1  0 = add, 1 = subtract.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) or borrow-in (subtract).
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
cout  output  1  raw carry out of the internal addition.
ovf  output  1  signed two's-complement overflow.
zero  output  1  sum equals 0.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - in_ready = 1; out_valid, sum, cout, ovf and zero = 0.
  - All internal shift, count and carry registers = 0.
- Internal arithmetic:
  - Add: a + b + cin.
  - Subtract: a + ~b + ~cin, which equals a - b - cin.
  - cout is the raw carry, so in subtract mode cout = 1 means no borrow.
- States:
  - IDLE: in_ready = 1.
    - On an edge with in_valid = 1, latch a, b (inverted if op_sub = 1), the initial carry and op_sub.
    - Clear the digit counter, then go to RUN.
  - RUN: in_ready = 0.
    - Each edge adds digit k (LSB first) of both operand registers plus the stored carry.
    - Store the DIGIT result bits into the internal sum shift register, update the carry, increment k.
    - On the edge that processes digit N-1 (N = WIDTH/DIGIT), load the output registers and go to DONE:
      - sum takes the full result.
      - cout takes the carry out of bit WIDTH-1.
      - ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
      - zero = (result == 0).
      - out_valid is set to 1.
  - DONE: in_ready = 0; out_valid = 1.
    - On an edge with out_ready = 1: out_valid goes to 0 and state goes to IDLE.
    - Otherwise hold.
- Latency: out_valid rises on the N-th rising edge after the accepting edge (N = 4 for the defaults). Minimum spacing between accepts is N+2 cycles.
- sum, cout, ovf and zero change only on the completion edge. They hold the last result through DONE, IDLE and the next RUN.
- Intermediate digits are never visible on sum.
- Boundary conditions:
  - in_valid outside IDLE is ignored; operands are not re-sampled mid-operation.
  - Changes to a, b, op_sub or cin after acceptance have no effect.
  - out_ready while out_valid = 0 has no effect.
  - DIGIT = WIDTH: RUN lasts one cycle, N = 1.
  - Digit counter width is ceil(log2(N)) with a minimum of 1.
  - The counter never wraps: the RUN exit is taken at N-1.
  - Reset asserted in RUN or DONE aborts the operation immediately. All outputs return to their reset values, and the partial result is discarded.
  - First accept is possible on the first edge after reset release.

Test Plan:
1. Add, defaults (WIDTH=8, DIGIT=2): a=0x3C, b=0x05, cin=0, op_sub=0 -> out_valid on the 4th edge after accept; sum=0x41, cout=0, ovf=0, zero=0; in_ready=0 from accept until return to IDLE.
2. Subtract: a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x10, b=0x10, cin=0 -> sum=0x00, cout=1, zero=1. Then a=0x10, b=0x0F, cin=1 -> sum=0x00, cout=1, zero=1.
3. Overflow and carry:
   - 0x7F + 0x01 -> sum=0x80, ovf=1, cout=0.
   - 0x80 - 0x01 -> sum=0x7F, ovf=1, cout=1.
   - 0xFF + 0x00 with cin=1 -> sum=0x00, cout=1, ovf=0, zero=1.
4. Backpressure: hold out_ready=0 for 10 cycles after completion while pulsing in_valid with new operands -> out_valid stays 1, sum/flags stay stable, in_ready stays 0, new operands are ignored. Raise out_ready for one cycle -> IDLE; the next op is accepted and computed correctly.
5. Reset mid-operation: deassert rst_n on the 2nd RUN cycle -> all outputs are 0 immediately. After release, in_ready=1, and 0x12 + 0x34 gives sum=0x46 with the correct latency.
6. Parameter sweep: WIDTH=4/DIGIT=1 (latency 4), WIDTH=8/DIGIT=8 (latency 1) and WIDTH=16/DIGIT=4 (latency 4). Run 1,000 random ops each, both modes, against a behavioural a±b±cin model checking sum, cout, ovf and zero.
